// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared definitions for the JTAG TAP controller slice:
//   - the 16 TAP state codes (standard 1149.1 encoding) and the state enum
//   - the instruction opcodes and the data-register select enum
//   - the instruction register width, its capture value and the IDCODE value
package jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] IR_CAPTURE   = 4'b0001;
    localparam logic [31:0]     IDCODE_VALUE = 32'h1234_5093;

    // Instruction opcodes
    localparam logic [IR_W-1:0] INS_EXTEST = 4'b0000;
    localparam logic [IR_W-1:0] INS_SAMPLE = 4'b0001;
    localparam logic [IR_W-1:0] INS_IDCODE = 4'b0010;
    localparam logic [IR_W-1:0] INS_BYPASS = 4'b1111;

    // TAP state codes
    localparam logic [3:0] ST_TLR     = 4'hF;
    localparam logic [3:0] ST_RTI     = 4'hC;
    localparam logic [3:0] ST_SELDR   = 4'h7;
    localparam logic [3:0] ST_CAPDR   = 4'h6;
    localparam logic [3:0] ST_SHDR    = 4'h2;
    localparam logic [3:0] ST_EX1DR   = 4'h1;
    localparam logic [3:0] ST_PAUSEDR = 4'h3;
    localparam logic [3:0] ST_EX2DR   = 4'h0;
    localparam logic [3:0] ST_UPDDR   = 4'h5;
    localparam logic [3:0] ST_SELIR   = 4'h4;
    localparam logic [3:0] ST_CAPIR   = 4'hE;
    localparam logic [3:0] ST_SHIR    = 4'hA;
    localparam logic [3:0] ST_EX1IR   = 4'h9;
    localparam logic [3:0] ST_PAUSEIR = 4'hB;
    localparam logic [3:0] ST_EX2IR   = 4'h8;
    localparam logic [3:0] ST_UPDIR   = 4'hD;

    typedef enum logic [3:0] {
        TAP_TLR     = ST_TLR,
        TAP_RTI     = ST_RTI,
        TAP_SELDR   = ST_SELDR,
        TAP_CAPDR   = ST_CAPDR,
        TAP_SHDR    = ST_SHDR,
        TAP_EX1DR   = ST_EX1DR,
        TAP_PAUSEDR = ST_PAUSEDR,
        TAP_EX2DR   = ST_EX2DR,
        TAP_UPDDR   = ST_UPDDR,
        TAP_SELIR   = ST_SELIR,
        TAP_CAPIR   = ST_CAPIR,
        TAP_SHIR    = ST_SHIR,
        TAP_EX1IR   = ST_EX1IR,
        TAP_PAUSEIR = ST_PAUSEIR,
        TAP_EX2IR   = ST_EX2IR,
        TAP_UPDIR   = ST_UPDIR
    } tap_state_e;

    // Data register currently routed onto TDO during Shift-DR
    typedef enum logic [1:0] {
        SEL_BSR,
        SEL_ID,
        SEL_BYPASS
    } dr_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm
// The 16-state TAP state machine plus Moore decodes of the state register.
// Ports:
//   tck_i         TAP clock
//   reset_i       synchronous active-high reset (forces Test-Logic-Reset)
//   tms_i         test mode select
//   state_o       current state
//   next_state_o  state that will be entered on the next TCK edge
//   shift_dr_o    high in Shift-DR
//   clock_dr_o    high in Capture-DR and Shift-DR
//   update_dr_o   high in Update-DR
//   tdo_en_o      high in Shift-DR or Shift-IR
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       reset_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output tap_state_e next_state_o,
    output logic       shift_dr_o,
    output logic       clock_dr_o,
    output logic       update_dr_o,
    output logic       tdo_en_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck_i) begin
        if (reset_i) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:     state_d = tms_i ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     state_d = tms_i ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   state_d = tms_i ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   state_d = tms_i ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    state_d = tms_i ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   state_d = tms_i ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: state_d = tms_i ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   state_d = tms_i ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   state_d = tms_i ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   state_d = tms_i ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   state_d = tms_i ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    state_d = tms_i ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   state_d = tms_i ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: state_d = tms_i ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   state_d = tms_i ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   state_d = tms_i ? TAP_SELDR   : TAP_RTI;
            default:     state_d = TAP_TLR;
        endcase
    end

    // Strobes decode only the registered state, so they are stable for the
    // whole cycle and change only on TCK edges.
    always_comb begin
        shift_dr_o  = 1'b0;
        clock_dr_o  = 1'b0;
        update_dr_o = 1'b0;
        tdo_en_o    = 1'b0;
        case (state_q)
            TAP_CAPDR: clock_dr_o = 1'b1;
            TAP_SHDR: begin
                shift_dr_o = 1'b1;
                clock_dr_o = 1'b1;
                tdo_en_o   = 1'b1;
            end
            TAP_UPDDR: update_dr_o = 1'b1;
            TAP_SHIR:  tdo_en_o    = 1'b1;
            default: ;
        endcase
    end

    assign state_o      = state_q;
    assign next_state_o = state_d;

endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller
// IEEE 1149.1-style TAP controller: TAP FSM, 4-bit instruction register,
// BYPASS and IDCODE data registers, TDO mux and boundary-cell strobes.
// Ports:
//   TCK_i        TAP clock
//   Reset_i      synchronous active-high reset
//   TMS_i        test mode select
//   TDI_i        serial data in
//   bsr_tdo_i    serial out of the last boundary cell
//   TDO_o        serial data out (LSB of the selected register)
//   TDO_en_o     high in Shift-DR / Shift-IR
//   ShiftDR_o    boundary cell shift strobe
//   ClockDR_o    boundary cell clock enable
//   UpdateDR_o   boundary cell update strobe
//   Mode_o       boundary cell test-path select (EXTEST)
//   tap_state_o  current TAP state code
module jtag_tap_controller
    import jtag_pkg::*;
(
    input  logic       TCK_i,
    input  logic       Reset_i,
    input  logic       TMS_i,
    input  logic       TDI_i,
    input  logic       bsr_tdo_i,
    output logic       TDO_o,
    output logic       TDO_en_o,
    output logic       ShiftDR_o,
    output logic       ClockDR_o,
    output logic       UpdateDR_o,
    output logic       Mode_o,
    output logic [3:0] tap_state_o
);

    tap_state_e state;
    tap_state_e next_state;

    logic [IR_W-1:0] ir_q,     ir_d;
    logic [IR_W-1:0] ir_sr_q,  ir_sr_d;
    logic            bypass_q, bypass_d;
    logic [31:0]     id_q,     id_d;

    dr_sel_e dr_sel;

    tap_fsm u_tap_fsm (
        .tck_i        (TCK_i),
        .reset_i      (Reset_i),
        .tms_i        (TMS_i),
        .state_o      (state),
        .next_state_o (next_state),
        .shift_dr_o   (ShiftDR_o),
        .clock_dr_o   (ClockDR_o),
        .update_dr_o  (UpdateDR_o),
        .tdo_en_o     (TDO_en_o)
    );

    always_ff @(posedge TCK_i) begin
        if (Reset_i) begin
            ir_q     <= INS_IDCODE;
            ir_sr_q  <= IR_CAPTURE;
            bypass_q <= 1'b0;
            id_q     <= IDCODE_VALUE;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
            id_q     <= id_d;
        end
    end

    // Capture/shift act on the edge that leaves the capture/shift state, so
    // they key off the current state. The active IR is forced to IDCODE on
    // the edge that enters (or stays in) Test-Logic-Reset, so it already reads
    // IDCODE during the first TLR cycle.
    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
        id_d     = id_q;
        case (state)
            TAP_CAPIR: ir_sr_d = IR_CAPTURE;
            TAP_SHIR:  ir_sr_d = {TDI_i, ir_sr_q[IR_W-1:1]};
            TAP_UPDIR: ir_d    = ir_sr_q;
            TAP_CAPDR: begin
                bypass_d = 1'b0;
                id_d     = IDCODE_VALUE;
            end
            TAP_SHDR: begin
                bypass_d = TDI_i;
                id_d     = {TDI_i, id_q[31:1]};
            end
            default: ;
        endcase
        if (next_state == TAP_TLR) begin
            ir_d = INS_IDCODE;
        end
    end

    // Unknown opcodes fall back to BYPASS.
    always_comb begin
        dr_sel = SEL_BYPASS;
        Mode_o = 1'b0;
        case (ir_q)
            INS_EXTEST: begin
                dr_sel = SEL_BSR;
                Mode_o = 1'b1;
            end
            INS_SAMPLE: dr_sel = SEL_BSR;
            INS_IDCODE: dr_sel = SEL_ID;
            default:    dr_sel = SEL_BYPASS;
        endcase
    end

    always_comb begin
        TDO_o = 1'b0;
        if (state == TAP_SHIR) begin
            TDO_o = ir_sr_q[0];
        end else if (state == TAP_SHDR) begin
            case (dr_sel)
                SEL_BSR: TDO_o = bsr_tdo_i;
                SEL_ID:  TDO_o = id_q[0];
                default: TDO_o = bypass_q;
            endcase
        end
    end

    assign tap_state_o = state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller
// Directed scoreboard bench: the stimulus process drives one TCK cycle at a
// time and queues the outputs expected after the following rising edge; a
// monitor pops one expectation per cycle and compares it.
module tb_jtag_tap_controller;

    logic       TCK = 1'b0;
    logic       Reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       bsrTdo = 1'b0;
    logic       TDO, TDO_en, ShiftDR, ClockDR, UpdateDR, Mode;
    logic [3:0] tapState;

    localparam logic [31:0] ID_VAL = 32'h1234_5093;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [4:0] flags;
        logic       tdo;
    } expect_t;

    expect_t sb[$];
    int      total = 0;
    int      bad = 0;
    logic    expMode = 1'b0;
    logic    nextBsr = 1'b0;
    logic [31:0] idVal = ID_VAL;

    jtag_tap_controller dut (
        .TCK_i       (TCK),
        .Reset_i     (Reset),
        .TMS_i       (TMS),
        .TDI_i       (TDI),
        .bsr_tdo_i   (bsrTdo),
        .TDO_o       (TDO),
        .TDO_en_o    (TDO_en),
        .ShiftDR_o   (ShiftDR),
        .ClockDR_o   (ClockDR),
        .UpdateDR_o  (UpdateDR),
        .Mode_o      (Mode),
        .tap_state_o (tapState)
    );

    always #5 TCK = ~TCK;

    // {ShiftDR, ClockDR, UpdateDR, Mode, TDO_en} expected for a given state
    function automatic logic [4:0] strobesFor(input logic [3:0] st, input logic md);
        return {st == 4'h2, (st == 4'h6) || (st == 4'h2), st == 4'h5, md,
                (st == 4'h2) || (st == 4'hA)};
    endfunction

    task automatic applyStimulus(input logic rst, input logic tms, input logic tdi,
                                 input logic [3:0] st, input logic tdo, input string name);
        expect_t e;
        @(negedge TCK);
        Reset  = rst;
        TMS    = tms;
        TDI    = tdi;
        bsrTdo = nextBsr;
        e.name  = name;
        e.st    = st;
        e.flags = strobesFor(st, expMode);
        e.tdo   = tdo;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        logic [4:0] got;
        got = {ShiftDR, ClockDR, UpdateDR, Mode, TDO_en};
        total++;
        if (tapState !== e.st) begin
            bad++;
            $display("[TB] FAIL %s state: got %h want %h", e.name, tapState, e.st);
        end
        total++;
        if (got !== e.flags) begin
            bad++;
            $display("[TB] FAIL %s strobes{sdr,cdr,udr,mode,en}: got %b want %b",
                     e.name, got, e.flags);
        end
        total++;
        if (TDO !== e.tdo) begin
            bad++;
            $display("[TB] FAIL %s tdo: got %b want %b", e.name, TDO, e.tdo);
        end
    endtask

    task automatic checkIr(input logic [3:0] want, input string name);
        @(posedge TCK);
        #2;
        total++;
        if (dut.ir_q !== want) begin
            bad++;
            $display("[TB] FAIL %s ir: got %b want %b", name, dut.ir_q, want);
        end
    endtask

    // From RTI: full IR scan of val, ending back in RTI
    task automatic scanIr(input logic [3:0] val, input logic newMode);
        logic [3:0] sr;
        applyStimulus(0, 1, 0, 4'h7, 0, "irSelDr");
        applyStimulus(0, 1, 0, 4'h4, 0, "irSelIr");
        applyStimulus(0, 0, 0, 4'hE, 0, "irCap");
        applyStimulus(0, 0, 0, 4'hA, 1, "irShCapBit");
        sr = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            sr = {val[i], sr[3:1]};
            if (i == 3) applyStimulus(0, 1, val[i], 4'h9, 0, "irEx1");
            else        applyStimulus(0, 0, val[i], 4'hA, sr[0], "irShift");
        end
        applyStimulus(0, 1, 0, 4'hD, 0, "irUpd");
        expMode = newMode;
        applyStimulus(0, 0, 0, 4'hC, 0, "irRtiNewIr");
    endtask

    // From RTI: DR scan with bypass selected, pattern 1,0,1,1
    task automatic bypassDr();
        applyStimulus(0, 1, 0, 4'h7, 0, "bypSelDr");
        applyStimulus(0, 0, 0, 4'h6, 0, "bypCap");
        applyStimulus(0, 0, 0, 4'h2, 0, "bypCapturedZero");
        applyStimulus(0, 0, 1, 4'h2, 1, "bypEcho1");
        applyStimulus(0, 0, 0, 4'h2, 0, "bypEcho0");
        applyStimulus(0, 0, 1, 4'h2, 1, "bypEcho1b");
        applyStimulus(0, 1, 1, 4'h1, 0, "bypEx1");
        applyStimulus(0, 1, 0, 4'h5, 0, "bypUpd");
        applyStimulus(0, 0, 0, 4'hC, 0, "bypRti");
    endtask

    // From RTI: DR scan with the boundary chain selected
    task automatic bsrDr();
        applyStimulus(0, 1, 0, 4'h7, 0, "bsrSelDr");
        applyStimulus(0, 0, 0, 4'h6, 0, "bsrCap");
        nextBsr = 1'b1;
        applyStimulus(0, 0, 0, 4'h2, 1, "bsrRoute1");
        nextBsr = 1'b0;
        applyStimulus(0, 0, 0, 4'h2, 0, "bsrRoute0");
        applyStimulus(0, 1, 0, 4'h1, 0, "bsrEx1");
        applyStimulus(0, 1, 0, 4'h5, 0, "bsrUpd");
        applyStimulus(0, 0, 0, 4'hC, 0, "bsrRti");
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after the edge
    initial begin
        forever begin
            @(posedge TCK);
            #1;
            if (sb.size() != 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        $display("[TB] start");
        // Reset, including reset winning over TMS=0
        applyStimulus(1, 1, 0, 4'hF, 0, "reset0");
        applyStimulus(1, 0, 0, 4'hF, 0, "resetTms0");
        checkIr(4'b0010, "irAfterReset");
        applyStimulus(0, 0, 0, 4'hC, 0, "rtiAfterReset");

        // IDCODE read, LSB first
        applyStimulus(0, 1, 0, 4'h7, 0, "idSelDr");
        applyStimulus(0, 0, 0, 4'h6, 0, "idCap");
        applyStimulus(0, 0, 0, 4'h2, idVal[0], "idBit0");
        for (int i = 1; i < 32; i++) applyStimulus(0, 0, 0, 4'h2, idVal[i], "idBit");
        applyStimulus(0, 1, 0, 4'h1, 0, "idEx1");
        applyStimulus(0, 1, 0, 4'h5, 0, "idUpd");
        applyStimulus(0, 0, 0, 4'hC, 0, "idRti");

        // EXTEST: Mode=1 after UpdIR and throughout a DR scan
        scanIr(4'b0000, 1'b1);
        bsrDr();

        // BYPASS, then an unknown opcode behaving the same
        scanIr(4'b1111, 1'b0);
        bypassDr();
        scanIr(4'b0101, 1'b0);
        bypassDr();

        // SAMPLE: boundary chain routed but Mode stays 0
        scanIr(4'b0001, 1'b0);
        bsrDr();

        // Through SelIR to TLR restores IDCODE
        applyStimulus(0, 1, 0, 4'h7, 0, "tlrSelDr");
        applyStimulus(0, 1, 0, 4'h4, 0, "tlrSelIr");
        applyStimulus(0, 1, 0, 4'hF, 0, "tlrEnter");
        checkIr(4'b0010, "irInTlr");
        applyStimulus(0, 0, 0, 4'hC, 0, "tlrRti");

        // Pause in the middle of an ID read
        applyStimulus(0, 1, 0, 4'h7, 0, "pSelDr");
        applyStimulus(0, 0, 0, 4'h6, 0, "pCap");
        applyStimulus(0, 0, 0, 4'h2, idVal[0], "pBit0");
        for (int i = 1; i < 5; i++) applyStimulus(0, 0, 0, 4'h2, idVal[i], "pBit");
        applyStimulus(0, 1, 0, 4'h1, 0, "pEx1");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 4'h3, 0, "pPause");
        applyStimulus(0, 1, 0, 4'h0, 0, "pEx2");
        applyStimulus(0, 0, 0, 4'h2, idVal[5], "pResumeBit5");
        for (int i = 6; i < 8; i++) applyStimulus(0, 0, 0, 4'h2, idVal[i], "pBitAfter");
        applyStimulus(0, 1, 0, 4'h1, 0, "pEx1b");
        applyStimulus(0, 1, 0, 4'h5, 0, "pUpd");
        applyStimulus(0, 0, 0, 4'hC, 0, "pRti");

        // Recovery: IR=EXTEST, park in PauseIR with 0000 in the shifter,
        // then TMS=1 for five edges
        scanIr(4'b0000, 1'b1);
        applyStimulus(0, 1, 0, 4'h7, 0, "rSelDr");
        applyStimulus(0, 1, 0, 4'h4, 0, "rSelIr");
        applyStimulus(0, 0, 0, 4'hE, 0, "rCap");
        applyStimulus(0, 0, 0, 4'hA, 1, "rShCap");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 4'hA, 0, "rShift");
        applyStimulus(0, 1, 0, 4'h9, 0, "rEx1");
        applyStimulus(0, 0, 0, 4'hB, 0, "rPauseIr");
        applyStimulus(0, 1, 0, 4'h8, 0, "rTms1a");
        applyStimulus(0, 1, 0, 4'hD, 0, "rTms1b");
        applyStimulus(0, 1, 0, 4'h7, 0, "rTms1c");
        applyStimulus(0, 1, 0, 4'h4, 0, "rTms1d");
        expMode = 1'b0;
        applyStimulus(0, 1, 0, 4'hF, 0, "rTms1eTlr");
        checkIr(4'b0010, "irAfterRecovery");

        // Reset asserted while in Shift-DR
        applyStimulus(0, 0, 0, 4'hC, 0, "sRti");
        applyStimulus(0, 1, 0, 4'h7, 0, "sSelDr");
        applyStimulus(0, 0, 0, 4'h6, 0, "sCap");
        applyStimulus(0, 0, 0, 4'h2, idVal[0], "sShDr");
        applyStimulus(1, 0, 0, 4'hF, 0, "sResetInShDr");
        applyStimulus(0, 0, 0, 4'hC, 0, "sRtiAfterReset");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge TCK);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
